// File: rtl/dcache_if.sv
// Pipeline and backing-memory signals of the data-cache controller, grouped
// so the cache side (slave) and the pipeline/memory side (master) bind as one port.
interface dcache_if #(
  parameter int WIDTH       = 32,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WORD_W = $clog2(BLOCK_WORDS);

  logic              read_M;
  logic              write_M;
  logic [WIDTH-1:0]  addr_M;
  logic              hit;
  logic              stall;
  logic              line_we;
  logic [IDX_W-1:0]  line_idx;
  logic [WORD_W-1:0] line_word;
  // mem_req is held with a stable mem_addr/mem_we until mem_ack; a one-cycle
  // mem_ack completes the transfer, and mem_ack while mem_req=0 is ignored.
  logic              mem_req;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_addr;
  logic              mem_ack;
  logic [1:0]        dbg_state;

  modport slave (
    input  read_M, write_M, addr_M, mem_ack,
    output hit, stall, line_we, line_idx, line_word,
           mem_req, mem_we, mem_addr, dbg_state
  );

  modport master (
    output read_M, write_M, addr_M, mem_ack,
    input  hit, stall, line_we, line_idx, line_word,
           mem_req, mem_we, mem_addr, dbg_state
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller:
// valid/tag arrays, hit detection, line refill and store write-through sequencing.
module dcache_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic     clk,
  input  logic     rst,
  dcache_if.slave  bus
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W  = WIDTH - IDX_W - WORD_W - 2;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]    base_tag_q, base_tag_d;
  logic [IDX_W-1:0]    base_idx_q, base_idx_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [SETS];
  logic                tag_we;

  logic [TAG_W-1:0]    a_tag;
  logic [IDX_W-1:0]    a_idx;
  logic                hit;
  logic                stall;
  logic                mem_req;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_addr;
  logic                line_we;

  assign a_tag = bus.addr_M[WIDTH-1 -: TAG_W];
  assign a_idx = bus.addr_M[WORD_W+2 +: IDX_W];
  assign hit   = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_tag_d = base_tag_q;
    base_idx_d = base_idx_q;
    valid_d    = valid_q;
    tag_we     = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    line_we    = 1'b0;
    case (state_q)
      IDLE: begin
        // A store wins over a load when both are flagged in the same cycle.
        if (bus.write_M) begin
          stall   = 1'b1;
          state_d = WRITE;
        end else if (bus.read_M && !hit) begin
          stall      = 1'b1;
          base_tag_d = a_tag;
          base_idx_d = a_idx;
          cnt_d      = '0;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {base_tag_q, base_idx_q, cnt_q, 2'b00};
        if (bus.mem_ack) begin
          line_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            tag_we              = 1'b1;
            valid_d[base_idx_q] = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      WRITE: begin
        // The pipeline is frozen, so addr_M holds the store address throughout.
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = bus.addr_M & ~WIDTH'(3);
        if (bus.mem_ack) state_d = WDONE;
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_tag_q <= '0;
      base_idx_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_tag_q <= base_tag_d;
      base_idx_q <= base_idx_d;
      valid_q    <= valid_d;
    end
  end

  // Tag storage needs no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (tag_we && !rst) tag_q[base_idx_q] <= base_tag_q;
  end

  assign bus.hit       = hit;
  assign bus.stall     = stall;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.line_we   = line_we;
  assign bus.line_idx  = base_idx_q;
  assign bus.line_word = cnt_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: refills, evictions, store write-through,
// read/write priority, ignored stray acks and reset in the middle of a refill.
module tb_dcache_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dcache_if #(.WIDTH(32), .SETS(16), .BLOCK_WORDS(4)) bus ();

  dcache_ctrl #(.WIDTH(32), .SETS(16), .BLOCK_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic ack);
    bus.read_M  = r;
    bus.write_M = w;
    bus.addr_M  = a;
    bus.mem_ack = ack;
  endtask

  // Load that must miss in IDLE; leaves the controller entering REFILL.
  task automatic miss_start(input logic [31:0] a);
    drive(1'b1, 1'b0, a, 1'b0);
    #1;
    chk("miss_hit", 32'(bus.hit), 32'd0);
    chk("miss_stall", 32'(bus.stall), 32'd1);
    chk("miss_req_idle", 32'(bus.mem_req), 32'd0);
    tick();
  endtask

  // Four back-to-back acks, then the load must hit without a stall.
  task automatic refill(input logic [31:0] base, input logic [31:0] idx);
    for (int k = 0; k < 4; k++) begin
      bus.mem_ack = 1'b1;
      #1;
      chk("rf_req", 32'(bus.mem_req), 32'd1);
      chk("rf_we", 32'(bus.mem_we), 32'd0);
      chk("rf_addr", bus.mem_addr, base + 32'(4 * k));
      chk("rf_line_we", 32'(bus.line_we), 32'd1);
      chk("rf_line_idx", 32'(bus.line_idx), idx);
      chk("rf_line_word", 32'(bus.line_word), 32'(k));
      chk("rf_stall", 32'(bus.stall), 32'd1);
      tick();
    end
    bus.mem_ack = 1'b0;
    #1;
    chk("rf_done_hit", 32'(bus.hit), 32'd1);
    chk("rf_done_stall", 32'(bus.stall), 32'd0);
    chk("rf_done_line_we", 32'(bus.line_we), 32'd0);
    chk("rf_done_req", 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(bus.dbg_state), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_line_we", 32'(bus.line_we), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);

    // Stray ack with no request must not disturb IDLE.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("stray_state", 32'(bus.dbg_state), 32'd0);
    chk("stray_line_we", 32'(bus.line_we), 32'd0);
    bus.mem_ack = 1'b0;

    // Cold miss at 0x40, refill words 0..3 into line 4.
    miss_start(32'h40);
    chk("refill_state", 32'(bus.dbg_state), 32'd1);
    chk("refill_first_addr", bus.mem_addr, 32'h40);
    refill(32'h40, 32'd4);

    // Same index, different tag: evicts and refills, then 0x40 misses again.
    miss_start(32'h140);
    refill(32'h140, 32'd4);
    miss_start(32'h40);
    refill(32'h40, 32'd4);

    // Store miss at 0x80 with the ack in the third request cycle.
    drive(1'b0, 1'b1, 32'h80, 1'b0);
    #1;
    chk("st_idle_stall", 32'(bus.stall), 32'd1);
    chk("st_idle_hit", 32'(bus.hit), 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.mem_ack = 1'b1;
      #1;
      chk("st_req", 32'(bus.mem_req), 32'd1);
      chk("st_we", 32'(bus.mem_we), 32'd1);
      chk("st_addr", bus.mem_addr, 32'h80);
      chk("st_stall", 32'(bus.stall), 32'd1);
      chk("st_line_we", 32'(bus.line_we), 32'd0);
      tick();
    end
    bus.mem_ack = 1'b0;
    #1;
    chk("st_wdone_state", 32'(bus.dbg_state), 32'd3);
    chk("st_wdone_stall", 32'(bus.stall), 32'd0);
    chk("st_wdone_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("st_back_idle", 32'(bus.dbg_state), 32'd0);
    miss_start(32'h80);
    refill(32'h80, 32'd8);

    // Simultaneous read and write at a resident line: handled as a store.
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    #1;
    chk("rw_hit", 32'(bus.hit), 32'd1);
    chk("rw_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("rw_state", 32'(bus.dbg_state), 32'd2);
    bus.mem_ack = 1'b1;
    #1;
    chk("rw_mem_we", 32'(bus.mem_we), 32'd1);
    chk("rw_addr", bus.mem_addr, 32'h40);
    chk("rw_line_we", 32'(bus.line_we), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("rw_wdone_stall", 32'(bus.stall), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // Evict 0x40, then reset after two of its four refill acks.
    miss_start(32'h140);
    refill(32'h140, 32'd4);
    miss_start(32'h40);
    for (int k = 0; k < 2; k++) begin
      bus.mem_ack = 1'b1;
      #1;
      chk("part_addr", bus.mem_addr, 32'h40 + 32'(4 * k));
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h40, 1'b0);
    tick();
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    chk("mid_rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h140, 1'b0);
    #1;
    chk("mid_rst_valid_cleared", 32'(bus.hit), 32'd0);
    miss_start(32'h40);
    refill(32'h40, 32'd4);

    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
